serial_command_issuer: RTL and testbench
========================================

# serial_command_issuer

Host-side initiator for the board's serial memory-command protocol: accepts one word read or word write request at a time, transmits it as opcode, address and data bytes through the RS232 transmit handshake, then collects the response bytes from the RS232 receive side. It is used for board-to-board loopback and to test the serial command path from inside the FPGA. It sits between a requesting master (test sequencer or debug logic) and an RS232 instance (TX/start_TX/TX_ready, RX/hasRX).

## Interface

- TIMEOUT_CYCLES, 1000000, idle clk cycles allowed between response bytes before abort
- WRITE_OPCODE, 8'h57, first byte of a write command ('W')
- READ_OPCODE, 8'h52, first byte of a read command ('R')
- ACK_BYTE, 8'h06, single-byte response that confirms a write

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  request present
- cmd_ready  out  1  issuer idle, request accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  32  word address
- cmd_data  in  32  write data (ignored for reads)
- resp_valid  out  1  one-cycle pulse, response fields valid
- resp_data  out  32  read word (0 for writes)
- resp_error  out  1  write answered with a byte other than ACK_BYTE
- resp_timeout  out  1  response not completed within TIMEOUT_CYCLES
- TX  out  8  byte to transmit
- start_TX  out  1  one-cycle transmit strobe
- TX_ready  in  1  transmitter can accept a byte
- RX  in  8  received byte
- RX_ready  in  1  one-cycle pulse, RX valid

## Operation

- States: IDLE, STROBE, GAP, RECV, DONE.
- IDLE: cmd_ready=1. On accept, register cmd_write, cmd_address and cmd_data. Build byte sequence: write = WRITE_OPCODE, address[31:24..7:0], data[31:24..7:0] (9 bytes); read = READ_OPCODE, address MSB first (5 bytes). Set index=0 and go to STROBE.
- STROBE: wait for TX_ready=1. Drive TX=byte[index] and start_TX=1 for exactly one cycle, then go to GAP.
- GAP: one cycle, start_TX=0, which lets TX_ready fall. If index is the last byte, go to RECV. Otherwise increment index and return to STROBE.
- RECV: clear byte counter and timeout counter on entry. On each RX_ready pulse, shift RX into resp_data from the low end (first byte ends up in [31:24]), increment the byte count and clear the timeout counter.
  - Write completes after 1 byte. resp_error=1 if RX != ACK_BYTE.
  - Read completes after 4 bytes.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without a byte, complete with resp_timeout=1 and resp_data=0.
- DONE: resp_valid=1 for one cycle with resp_data, resp_error and resp_timeout. The response fields hold their values until the next accept. Next state is IDLE.
- RX_ready pulses outside RECV are discarded. Bytes that arrive after completion are not buffered.
- Write responses report resp_data=0.

## Timing

- Reset values: cmd_ready=0 during reset and 1 the first cycle after it is released. start_TX=0, TX=0, resp_valid=0, resp_data=0, resp_error=0, resp_timeout=0. State is IDLE.
- Accept cycle: cmd_ready drops the next cycle. The earliest start_TX is 1 cycle after accept.
- Back-to-back strobes are at least 2 cycles apart. start_TX is never asserted while TX_ready=0.
- Completion: resp_valid is asserted the cycle after the final RX_ready, or after the timeout expiry cycle. cmd_ready=1 the cycle after resp_valid.
- A RX_ready in the same cycle as timeout expiry counts as a byte; the byte wins and the timeout does not fire.
- Timeout counter is 32 bits wide and saturates; it does not wrap.
- rst asserted mid-command aborts immediately. Any partially sent command is abandoned and no resp_valid is produced.
- Minimum command latency with TX_ready always 1: write takes 18 cycles to the last strobe; read takes 10.

## Test plan

- Write 0x00000010 ← 0xDEADBEEF, TX_ready held 1, ACK 0x06 returned -> TX bytes 57 00 00 00 10 DE AD BE EF, each as a single start_TX pulse; one resp_valid with resp_error=0, resp_timeout=0, resp_data=0.
- Read 0x00000004, responder returns 12 34 56 78 -> TX bytes 52 00 00 00 04; resp_valid with resp_data=0x12345678.
- Write answered with 0x15 -> resp_valid with resp_error=1; next command accepted the following cycle.
- Read with only 2 response bytes, TIMEOUT_CYCLES=100 -> resp_timeout=1 and resp_data=0 exactly 100 cycles after the second byte.
- TX_ready stalled low for 50 cycles mid-command, RX_ready pulses injected while in IDLE -> no start_TX while TX_ready=0, byte order preserved, stray bytes ignored.
- rst pulsed after the third transmitted byte -> outputs return to reset values, no resp_valid, and a new read then completes normally.

Source files
------------

// File: rtl/serial_command_issuer.sv
// serial_command_issuer: host-side initiator for the serial memory-command
// protocol. Sends one read or write command (opcode, address, data) through
// the RS232 transmit handshake and collects the response bytes.
module serial_command_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  WRITE_OPCODE   = 8'h57,
    parameter logic [7:0]  READ_OPCODE    = 8'h52,
    parameter logic [7:0]  ACK_BYTE       = 8'h06
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_address,
    input  logic [31:0] cmd_data,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error,
    output logic        resp_timeout,
    output logic [7:0]  TX,
    output logic        start_TX,
    input  logic        TX_ready,
    input  logic [7:0]  RX,
    input  logic        RX_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_GAP,
        S_RECV,
        S_DONE
    } state_t;

    // Idle count at which the response is abandoned.
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;

    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [3:0]  r_idx;
    logic [1:0]  r_rx_cnt;
    logic [31:0] r_to_cnt;
    logic [31:0] r_resp_data;
    logic        r_resp_error;
    logic        r_resp_timeout;

    logic        w_accept;
    logic        w_last_tx;
    logic        w_rx_done;
    logic        w_expire;
    logic [7:0]  w_tx_byte;

    assign w_accept  = cmd_valid & cmd_ready;
    assign w_last_tx = (r_idx == (r_write ? 4'd8 : 4'd4));
    // A write needs only the ACK byte; a read needs four data bytes.
    assign w_rx_done = RX_ready & (r_write | (r_rx_cnt == 2'd3));
    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_expire  = ~RX_ready & (r_to_cnt == TO_LAST);

    assign resp_data    = r_resp_data;
    assign resp_error   = r_resp_error;
    assign resp_timeout = r_resp_timeout;

    // Select the command byte for the current transmit index.
    always_comb begin
        w_tx_byte = 8'h00;
        case (r_idx)
            4'd0: w_tx_byte = r_write ? WRITE_OPCODE : READ_OPCODE;
            4'd1: w_tx_byte = r_addr[31:24];
            4'd2: w_tx_byte = r_addr[23:16];
            4'd3: w_tx_byte = r_addr[15:8];
            4'd4: w_tx_byte = r_addr[7:0];
            4'd5: w_tx_byte = r_data[31:24];
            4'd6: w_tx_byte = r_data[23:16];
            4'd7: w_tx_byte = r_data[15:8];
            4'd8: w_tx_byte = r_data[7:0];
            default: w_tx_byte = 8'h00;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake outputs. cmd_ready is masked by rst so the
    // issuer never looks ready while held in reset.
    always_comb begin
        w_next     = r_state;
        cmd_ready  = 1'b0;
        start_TX   = 1'b0;
        TX         = 8'h00;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid && !rst) w_next = S_STROBE;
            end
            S_STROBE: begin
                TX = w_tx_byte;
                if (TX_ready) begin
                    start_TX = 1'b1;
                    w_next   = S_GAP;
                end
            end
            S_GAP: begin
                // Dead cycle lets the transmitter drop TX_ready.
                w_next = w_last_tx ? S_RECV : S_STROBE;
            end
            S_RECV: begin
                if (w_rx_done || w_expire) w_next = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command capture, byte index, response assembly and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write        <= 1'b0;
            r_addr         <= 32'h0;
            r_data         <= 32'h0;
            r_idx          <= 4'd0;
            r_rx_cnt       <= 2'd0;
            r_to_cnt       <= 32'h0;
            r_resp_data    <= 32'h0;
            r_resp_error   <= 1'b0;
            r_resp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write        <= cmd_write;
                r_addr         <= cmd_address;
                r_data         <= cmd_data;
                r_idx          <= 4'd0;
                r_resp_data    <= 32'h0;
                r_resp_error   <= 1'b0;
                r_resp_timeout <= 1'b0;
            end
            if (r_state == S_GAP) begin
                if (w_last_tx) begin
                    r_rx_cnt <= 2'd0;
                    r_to_cnt <= 32'h0;
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
            end
            if (r_state == S_RECV) begin
                if (RX_ready) begin
                    r_rx_cnt <= r_rx_cnt + 2'd1;
                    r_to_cnt <= 32'h0;
                    // Write responses keep resp_data at zero.
                    if (r_write) r_resp_error <= (RX != ACK_BYTE);
                    else         r_resp_data  <= {r_resp_data[23:0], RX};
                end else if (w_expire) begin
                    r_resp_timeout <= 1'b1;
                    r_resp_data    <= 32'h0;
                end else if (r_to_cnt != 32'hFFFF_FFFF) begin
                    r_to_cnt <= r_to_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_command_issuer.sv
// Directed bench for serial_command_issuer: write/read transfers, NAK,
// response timeout, transmit stall with stray RX bytes, mid-command reset.
module tb_serial_command_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_address;
    logic [31:0] cmd_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        resp_timeout;
    logic [7:0]  TX;
    logic        start_TX;
    logic        TX_ready;
    logic [7:0]  RX;
    logic        RX_ready;

    serial_command_issuer #(
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_data(cmd_data),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_error(resp_error), .resp_timeout(resp_timeout),
        .TX(TX), .start_TX(start_TX), .TX_ready(TX_ready),
        .RX(RX), .RX_ready(RX_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int viol  = 0;
    int rv_cnt = 0;
    logic [7:0] txq[$];
    int         stq[$];
    logic [7:0] expb[9];
    int acc_cyc, rx_cyc, rv_cyc;
    bit got;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe and response pulse, mid-cycle.
    always @(negedge clk) begin
        if (start_TX) begin
            txq.push_back(TX);
            stq.push_back(cyc);
            if (!TX_ready) viol++;
        end
        if (resp_valid) rv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d);
        txq.delete(); stq.delete();
        cmd_valid = 1'b1; cmd_write = wr; cmd_address = a; cmd_data = d;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; acc_cyc = cyc; end
            tick();
        end
        cmd_valid = 1'b0;
        check("accept", 32'(got), 32'd1);
    endtask

    task automatic wait_strobes(input int n, input int budget);
        for (int i = 0; i < budget && txq.size() < n; i++) tick();
        check("strobe_count", 32'(txq.size()), 32'(n));
    endtask

    task automatic send_rx(input logic [7:0] b);
        RX = b; RX_ready = 1'b1; rx_cyc = cyc;
        tick();
        RX_ready = 1'b0; RX = 8'h00;
    endtask

    task automatic wait_resp(input int budget);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1'b1; rv_cyc = cyc; end
            tick();
        end
        check("resp_seen", 32'(got), 32'd1);
    endtask

    task automatic check_bytes(input string tag, input int n);
        for (int i = 0; i < n; i++)
            if (i < txq.size()) check(tag, 32'(txq[i]), 32'(expb[i]));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 32'h0;
        cmd_data = 32'h0; TX_ready = 1'b0; RX = 8'h00; RX_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_start_TX", 32'(start_TX), 32'd0);
        check("rst_TX", 32'(TX), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_flags", {30'd0, resp_error, resp_timeout}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();

        // Write 0x10 <- DEADBEEF, ACK
        TX_ready = 1'b1;
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        wait_strobes(9, 40);
        expb = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check_bytes("wr_tx_byte", 9);
        if (stq.size() == 9) begin
            check("wr_first_strobe", 32'(stq[0] - acc_cyc), 32'd1);
            check("wr_last_strobe", 32'(stq[8] - acc_cyc), 32'd17);
            for (int i = 1; i < 9; i++) check("wr_spacing", 32'(stq[i] - stq[i-1]), 32'd2);
        end
        tick();
        send_rx(8'h06);
        wait_resp(10);
        check("wr_resp_lat", 32'(rv_cyc - rx_cyc), 32'd1);
        check("wr_resp_data", resp_data, 32'h0);
        check("wr_resp_err", 32'(resp_error), 32'd0);
        check("wr_resp_to", 32'(resp_timeout), 32'd0);
        check("wr_resp_count", 32'(rv_cnt), 32'd1);

        // Read 0x4 -> 12345678
        issue(1'b0, 32'h0000_0004, 32'hFFFF_FFFF);
        wait_strobes(5, 30);
        expb = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        check_bytes("rd_tx_byte", 5);
        if (stq.size() == 5) check("rd_last_strobe", 32'(stq[4] - acc_cyc), 32'd9);
        tick();
        send_rx(8'h12); send_rx(8'h34); send_rx(8'h56); send_rx(8'h78);
        wait_resp(10);
        check("rd_resp_lat", 32'(rv_cyc - rx_cyc), 32'd1);
        check("rd_resp_data", resp_data, 32'h1234_5678);
        check("rd_resp_flags", {30'd0, resp_error, resp_timeout}, 32'd0);

        // Write answered with NAK 0x15
        issue(1'b1, 32'h0000_0020, 32'h0000_0001);
        wait_strobes(9, 40);
        tick();
        send_rx(8'h15);
        wait_resp(10);
        check("nak_resp_err", 32'(resp_error), 32'd1);
        check("nak_resp_data", resp_data, 32'h0);
        check("nak_resp_to", 32'(resp_timeout), 32'd0);

        // Next command accepted the cycle after resp_valid; read times out
        issue(1'b0, 32'h0000_0008, 32'h0);
        check("b2b_accept", 32'(acc_cyc - rv_cyc), 32'd1);
        wait_strobes(5, 30);
        tick();
        send_rx(8'hAB);
        tick();
        send_rx(8'hCD);
        wait_resp(150);
        // 100 idle cycles are allowed after the byte; resp_valid follows them.
        check("to_resp_lat", 32'(rv_cyc - rx_cyc), 32'd101);
        check("to_resp_to", 32'(resp_timeout), 32'd1);
        check("to_resp_data", resp_data, 32'h0);
        check("to_resp_err", 32'(resp_error), 32'd0);

        // Stray RX in IDLE, TX stall mid-command
        send_rx(8'h99); tick(); send_rx(8'h06);
        issue(1'b0, 32'h0000_0030, 32'h0);
        wait_strobes(3, 20);
        TX_ready = 1'b0;
        send_rx(8'h77);
        repeat (49) tick();
        check("stall_no_strobe", 32'(txq.size()), 32'd3);
        TX_ready = 1'b1;
        wait_strobes(5, 20);
        expb = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00};
        check_bytes("stall_tx_byte", 5);
        tick();
        send_rx(8'hA1); send_rx(8'hB2); send_rx(8'hC3); send_rx(8'hD4);
        wait_resp(10);
        check("stall_resp_data", resp_data, 32'hA1B2_C3D4);
        check("stall_resp_flags", {30'd0, resp_error, resp_timeout}, 32'd0);

        // Reset after third byte of a write
        issue(1'b1, 32'h0000_0040, 32'h5555_AAAA);
        wait_strobes(3, 20);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_start_TX", 32'(start_TX), 32'd0);
        check("mid_rst_TX", 32'(TX), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_after", 32'(cmd_ready), 32'd1);
        check("mid_rst_resp_data", resp_data, 32'h0);
        tick();
        repeat (5) tick();
        check("mid_rst_no_strobe", 32'(txq.size()), 32'd3);
        check("mid_rst_no_resp", 32'(rv_cnt), 32'd5);
        issue(1'b0, 32'h0000_0044, 32'h0);
        wait_strobes(5, 30);
        expb = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        check_bytes("post_rst_tx_byte", 5);
        tick();
        send_rx(8'hCA); send_rx(8'hFE); send_rx(8'hF0); send_rx(8'h0D);
        wait_resp(10);
        check("post_rst_resp_data", resp_data, 32'hCAFE_F00D);

        tick();
        check("strobe_while_not_ready", 32'(viol), 32'd0);
        check("resp_total", 32'(rv_cnt), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
